// File: rtl/keypad_entry_buffer.sv
// keypad_entry_buffer: keypad digit entry with backspace/enter and multiplexed digit display scan
module keypad_entry_buffer #(
    parameter int          DIGITS      = 4,
    parameter logic [3:0]  NO_KEY      = 4'hF,
    parameter logic [3:0]  STAR_KEY    = 4'hA,
    parameter logic [3:0]  HASH_KEY    = 4'hB,
    parameter logic [3:0]  BLANK       = 4'hF,
    parameter int          REFRESH_DIV = 4,
    localparam int         CW          = $clog2(DIGITS + 1)
) (
    input  logic                  scanClock,
    input  logic                  reset,
    input  logic [3:0]            keyValue,
    input  logic                  keyValid,
    output logic                  keyAck,
    output logic                  entered,
    output logic                  overflow,
    output logic [4*DIGITS-1:0]   committedValue,
    output logic [CW-1:0]         digitCount,
    output logic [DIGITS-1:0]     digitSelect,
    output logic [3:0]            digitCode
);
    localparam int BW = 4 * DIGITS;
    localparam int PW = $clog2(DIGITS);
    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    typedef enum logic {ARMED, HELD} state_t;
    state_t            state_q, state_d;
    logic [BW-1:0]     buf_q, buf_d, committed_q, committed_d;
    logic [CW-1:0]     count_q, count_d;
    logic              ack_q, ack_d, entered_q, entered_d, overflow_q, overflow_d;
    logic [RW-1:0]     ref_q, ref_d;
    logic [PW-1:0]     pos_q, pos_d;
    logic [DIGITS-1:0] sel_q, sel_d;
    logic [3:0]        code_q, code_d;
    logic              accept, wrap;
    always_comb begin
        accept = state_q == ARMED && keyValid && keyValue != NO_KEY;
        state_d = (state_q == ARMED) ? (accept ? HELD : ARMED)
                                     : ((keyValid && keyValue == NO_KEY) ? ARMED : HELD);
        ack_d = accept;
        entered_d = 1'b0;
        overflow_d = 1'b0;
        buf_d = buf_q;
        count_d = count_q;
        committed_d = committed_q;
        if (accept) begin
            if (keyValue <= 4'd9) begin
                if (count_q == CW'(DIGITS)) begin
                    overflow_d = 1'b1;
                end else begin
                    buf_d = {buf_q[BW-5:0], keyValue};
                    count_d = count_q + 1'b1;
                end
            end else if (keyValue == STAR_KEY && count_q != '0) begin
                buf_d = {BLANK, buf_q[BW-1:4]};
                count_d = count_q - 1'b1;
            end else if (keyValue == HASH_KEY && count_q != '0) begin
                committed_d = buf_q;
                buf_d = {DIGITS{BLANK}};
                count_d = '0;
                entered_d = 1'b1;
            end
        end
        // display position advances only on the refresh wrap; code is sampled with the new position
        wrap = ref_q == RW'(REFRESH_DIV - 1);
        ref_d = wrap ? '0 : ref_q + 1'b1;
        pos_d = wrap ? ((pos_q == PW'(DIGITS - 1)) ? '0 : pos_q + 1'b1) : pos_q;
        sel_d = {{(DIGITS-1){1'b0}}, 1'b1} << pos_d;
        code_d = buf_q[{pos_d, 2'b00} +: 4];
    end
    always_ff @(posedge scanClock) begin
        if (reset) begin
            state_q <= ARMED;
            buf_q <= {DIGITS{BLANK}};
            committed_q <= {DIGITS{BLANK}};
            count_q <= '0;
            ack_q <= 1'b0;
            entered_q <= 1'b0;
            overflow_q <= 1'b0;
            ref_q <= '0;
            pos_q <= '0;
            sel_q <= {{(DIGITS-1){1'b0}}, 1'b1};
            code_q <= BLANK;
        end else begin
            state_q <= state_d;
            buf_q <= buf_d;
            committed_q <= committed_d;
            count_q <= count_d;
            ack_q <= ack_d;
            entered_q <= entered_d;
            overflow_q <= overflow_d;
            ref_q <= ref_d;
            pos_q <= pos_d;
            sel_q <= sel_d;
            code_q <= code_d;
        end
    end
    assign keyAck = ack_q;
    assign entered = entered_q;
    assign overflow = overflow_q;
    assign committedValue = committed_q;
    assign digitCount = count_q;
    assign digitSelect = sel_q;
    assign digitCode = code_q;
endmodule
